// File: rtl/unidade_controle_ula_pkg.sv
// Shared types and constants for the RV64 multicycle control unit:
// FSM states, decoded operations, opcode/funct encodings and ALU operand selects.
package pkg_controle;

    typedef enum logic [2:0] {
        BUSCA,
        DECODIFICA,
        EXECUTA,
        MEMORIA,
        ESCRITA,
        ILEGAL
    } estado_t;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        ADDI,
        LD,
        SD,
        BEQ,
        INV
    } operacao_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_DOUBLE  = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    localparam logic [1:0] SEL_RS1 = 2'b00;
    localparam logic [1:0] SEL_RS2 = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    typedef struct packed {
        logic [1:0] entrada1;
        logic [1:0] entrada2;
        logic       subtraindo;
    } controle_ula_t;

    // ALU operand selects and add/sub control for a decoded operation.
    function automatic controle_ula_t controle_da_op(input operacao_t op);
        controle_ula_t c;
        c.entrada1   = SEL_RS1;
        c.entrada2   = SEL_RS2;
        c.subtraindo = 1'b0;
        case (op)
            SUB, BEQ:     c.subtraindo = 1'b1;
            ADDI, LD, SD: c.entrada2   = SEL_IMM;
            default:      ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_ula_decodificador.sv
// Combinational classifier: opcode/funct3/funct7 to the supported operation,
// anything outside the base subset maps to INV.
module decodificador_instrucao
    import pkg_controle::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] operacao
);

    operacao_t op;

    always_comb begin
        op = INV;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD_SUB) begin
                    if (funct7 == F7_ADD)      op = ADD;
                    else if (funct7 == F7_SUB) op = SUB;
                end
            end
            OPC_OP_IMM: if (funct3 == F3_ADD_SUB) op = ADDI;
            OPC_LOAD:   if (funct3 == F3_DOUBLE)  op = LD;
            OPC_STORE:  if (funct3 == F3_DOUBLE)  op = SD;
            OPC_BRANCH: if (funct3 == F3_BEQ)     op = BEQ;
            default:    ;
        endcase
    end

    assign operacao = op;

endmodule

// File: rtl/unidade_controle_ula.sv
// Multicycle control unit: fetch over req/ready, decode, then sequence ALU,
// memory, register-file and PC strobes. Every output is forced low during reset.
module unidade_controle_ula
    import pkg_controle::*;
#(
    parameter int BITS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [31:0] instrucao,
    input  logic       zero,
    input  logic       mem_pronta,
    output logic       mem_req,
    output logic       mem_escreve,
    output logic       endereco_ula,
    output logic       carrega_ir,
    output logic       carrega_pc,
    output logic       pc_fonte,
    output logic       escreve_reg,
    output logic       fonte_escrita,
    output logic [1:0] escolhe_entrada1,
    output logic [1:0] escolhe_entrada2,
    output logic       subtraindo,
    output logic       soma_ou_subtrai,
    output logic       instrucao_concluida,
    output logic       ilegal
);

    // The 32-bit instruction only fits the latch on datapaths at least 32 bits wide.
    localparam logic BITS_OK = (BITS >= 32);

    estado_t       estado, proximo;
    operacao_t     op_reg;
    logic [6:0]    opcode_q, funct7_q;
    logic [2:0]    funct3_q;
    logic [2:0]    op_dec_bits;
    operacao_t     op_dec;
    controle_ula_t ctl;
    logic          unused_campos;

    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_campos = ^{instrucao[24:15], instrucao[11:7]};

    decodificador_instrucao u_decodificador (
        .opcode   (opcode_q),
        .funct3   (funct3_q),
        .funct7   (funct7_q),
        .operacao (op_dec_bits)
    );

    assign op_dec = operacao_t'(op_dec_bits);
    assign ctl    = controle_da_op(op_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= BUSCA;
            op_reg   <= INV;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
        end else begin
            estado <= proximo;
            if (estado == BUSCA && mem_pronta && BITS_OK) begin
                opcode_q <= instrucao[6:0];
                funct3_q <= instrucao[14:12];
                funct7_q <= instrucao[31:25];
            end
            if (estado == DECODIFICA) op_reg <= op_dec;
        end
    end

    always_comb begin
        proximo             = estado;
        mem_req             = 1'b0;
        mem_escreve         = 1'b0;
        endereco_ula        = 1'b0;
        carrega_ir          = 1'b0;
        carrega_pc          = 1'b0;
        pc_fonte            = 1'b0;
        escreve_reg         = 1'b0;
        fonte_escrita       = 1'b0;
        escolhe_entrada1    = SEL_RS1;
        escolhe_entrada2    = SEL_RS1;
        subtraindo          = 1'b0;
        soma_ou_subtrai     = 1'b0;
        instrucao_concluida = 1'b0;
        ilegal              = 1'b0;

        if (!reset) begin
            // ALU controls stay valid from EXECUTA through the last cycle of the instruction.
            if (estado == EXECUTA || estado == MEMORIA || estado == ESCRITA) begin
                escolhe_entrada1 = ctl.entrada1;
                escolhe_entrada2 = ctl.entrada2;
                subtraindo       = ctl.subtraindo;
                soma_ou_subtrai  = 1'b1;
            end

            case (estado)
                BUSCA: begin
                    mem_req = 1'b1;
                    if (mem_pronta) begin
                        carrega_ir = 1'b1;
                        proximo    = DECODIFICA;
                    end
                end
                DECODIFICA: proximo = (op_dec == INV) ? ILEGAL : EXECUTA;
                EXECUTA: begin
                    case (op_reg)
                        BEQ: begin
                            carrega_pc          = 1'b1;
                            pc_fonte            = zero;
                            instrucao_concluida = 1'b1;
                            proximo             = BUSCA;
                        end
                        LD, SD:  proximo = MEMORIA;
                        default: proximo = ESCRITA;
                    endcase
                end
                MEMORIA: begin
                    mem_req      = 1'b1;
                    endereco_ula = 1'b1;
                    mem_escreve  = (op_reg == SD);
                    if (mem_pronta) begin
                        if (op_reg == SD) begin
                            carrega_pc          = 1'b1;
                            instrucao_concluida = 1'b1;
                            proximo             = BUSCA;
                        end else begin
                            proximo = ESCRITA;
                        end
                    end
                end
                ESCRITA: begin
                    escreve_reg         = 1'b1;
                    fonte_escrita       = (op_reg == LD);
                    carrega_pc          = 1'b1;
                    instrucao_concluida = 1'b1;
                    proximo             = BUSCA;
                end
                ILEGAL:  ilegal  = 1'b1;
                default: proximo = BUSCA;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_ula.sv
// Bench for unidade_controle_ula: per-cycle vector table over a program of
// instructions, plus hand sequences for illegal encodings and reset mid-transaction.
module tb_unidade_controle_ula;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208133;
    localparam logic [31:0] I_ADDI = 32'h00508193;
    localparam logic [31:0] I_LD   = 32'h0000B183;
    localparam logic [31:0] I_SD   = 32'h0020B023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_X    = 32'hFFFFFFFF;

    // Expected-output bit positions, same order as the saida concatenation below.
    localparam logic [15:0] B_REQ   = 16'h8000;
    localparam logic [15:0] B_ESC   = 16'h4000;
    localparam logic [15:0] B_END   = 16'h2000;
    localparam logic [15:0] B_IR    = 16'h1000;
    localparam logic [15:0] B_PC    = 16'h0800;
    localparam logic [15:0] B_PCF   = 16'h0400;
    localparam logic [15:0] B_REG   = 16'h0200;
    localparam logic [15:0] B_FONTE = 16'h0100;
    localparam logic [15:0] B_CONC  = 16'h0002;
    localparam logic [15:0] B_ILEG  = 16'h0001;
    localparam logic [15:0] A_RR    = 16'h0014;  // sel 00/01, add, enable
    localparam logic [15:0] A_RRS   = 16'h001C;  // sel 00/01, sub, enable
    localparam logic [15:0] A_RI    = 16'h0024;  // sel 00/10, add, enable

    typedef struct {
        logic [31:0] instr;
        logic        pronta;
        logic        z;
        logic [15:0] esperado;
    } vetor_t;

    logic        clk;
    logic        reset;
    logic [31:0] instrucao;
    logic        zero;
    logic        mem_pronta;
    logic        mem_req, mem_escreve, endereco_ula, carrega_ir, carrega_pc, pc_fonte;
    logic        escreve_reg, fonte_escrita, subtraindo, soma_ou_subtrai;
    logic        instrucao_concluida, ilegal;
    logic [1:0]  escolhe_entrada1, escolhe_entrada2;
    logic [15:0] saida;

    int n_cmp    = 0;
    int n_falhas = 0;
    vetor_t tabela[$];

    unidade_controle_ula #(.BITS(64)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instrucao           (instrucao),
        .zero                (zero),
        .mem_pronta          (mem_pronta),
        .mem_req             (mem_req),
        .mem_escreve         (mem_escreve),
        .endereco_ula        (endereco_ula),
        .carrega_ir          (carrega_ir),
        .carrega_pc          (carrega_pc),
        .pc_fonte            (pc_fonte),
        .escreve_reg         (escreve_reg),
        .fonte_escrita       (fonte_escrita),
        .escolhe_entrada1    (escolhe_entrada1),
        .escolhe_entrada2    (escolhe_entrada2),
        .subtraindo          (subtraindo),
        .soma_ou_subtrai     (soma_ou_subtrai),
        .instrucao_concluida (instrucao_concluida),
        .ilegal              (ilegal)
    );

    assign saida = {mem_req, mem_escreve, endereco_ula, carrega_ir, carrega_pc, pc_fonte,
                    escreve_reg, fonte_escrita, escolhe_entrada1, escolhe_entrada2,
                    subtraindo, soma_ou_subtrai, instrucao_concluida, ilegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic confere(input string nome, input logic [15:0] esperado);
        n_cmp++;
        if (saida !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %b expected %b", nome, saida, esperado);
        end
    endtask

    // Drive one cycle's inputs, check outputs at the falling edge, advance past the rising edge.
    task automatic aplica(input string nome, input logic [31:0] instr, input logic pronta,
                          input logic z, input logic [15:0] esperado);
        instrucao  = instr;
        mem_pronta = pronta;
        zero       = z;
        @(negedge clk);
        confere(nome, esperado);
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic [31:0] instr, input logic pronta, input logic z,
                       input logic [15:0] esperado);
        vetor_t v;
        v.instr = instr; v.pronta = pronta; v.z = z; v.esperado = esperado;
        tabela.push_back(v);
    endtask

    task automatic pulso_reset(input string nome);
        reset = 1'b1;
        #1;
        confere(nome, 16'h0000);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_pronta = 1'b0;
    endtask

    task automatic testa_ilegal(input string nome, input logic [31:0] instr, input int ciclos);
        aplica({nome, "_busca"}, instr, 1'b1, 1'b0, B_REQ | B_IR);
        aplica({nome, "_decod"}, I_X, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < ciclos; k++)
            aplica($sformatf("%s_sticky_%0d", nome, k), I_X, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), B_ILEG);
        pulso_reset({nome, "_reset"});
        aplica({nome, "_refetch"}, I_X, 1'b0, 1'b0, B_REQ);
    endtask

    initial begin
        reset      = 1'b1;
        instrucao  = '0;
        zero       = 1'b0;
        mem_pronta = 1'b0;

        // add, immediate ready; mem_pronta high outside BUSCA must be ignored
        vec(I_ADD, 1, 0, B_REQ | B_IR);
        vec(I_X,   1, 0, 16'h0000);
        vec(I_X,   1, 0, A_RR);
        vec(I_X,   1, 0, B_REG | B_PC | B_CONC | A_RR);
        // sub with two fetch wait cycles
        vec(I_X,   0, 0, B_REQ);
        vec(I_X,   0, 0, B_REQ);
        vec(I_SUB, 1, 0, B_REQ | B_IR);
        vec(I_X,   0, 0, 16'h0000);
        vec(I_X,   0, 0, A_RRS);
        vec(I_X,   0, 0, B_REG | B_PC | B_CONC | A_RRS);
        // addi
        vec(I_ADDI, 1, 0, B_REQ | B_IR);
        vec(I_X,    0, 0, 16'h0000);
        vec(I_X,    0, 0, A_RI);
        vec(I_X,    0, 0, B_REG | B_PC | B_CONC | A_RI);
        // ld with three memory wait cycles
        vec(I_LD, 1, 0, B_REQ | B_IR);
        vec(I_X,  0, 0, 16'h0000);
        vec(I_X,  0, 0, A_RI);
        vec(I_X,  0, 0, B_REQ | B_END | A_RI);
        vec(I_X,  0, 0, B_REQ | B_END | A_RI);
        vec(I_X,  0, 0, B_REQ | B_END | A_RI);
        vec(I_X,  1, 0, B_REQ | B_END | A_RI);
        vec(I_X,  0, 0, B_REG | B_FONTE | B_PC | B_CONC | A_RI);
        // beq taken
        vec(I_BEQ, 1, 1, B_REQ | B_IR);
        vec(I_X,   0, 1, 16'h0000);
        vec(I_X,   0, 1, A_RRS | B_PC | B_PCF | B_CONC);
        // beq not taken
        vec(I_BEQ, 1, 0, B_REQ | B_IR);
        vec(I_X,   0, 0, 16'h0000);
        vec(I_X,   0, 0, A_RRS | B_PC | B_CONC);
        // sd with one memory wait cycle
        vec(I_SD, 1, 0, B_REQ | B_IR);
        vec(I_X,  0, 0, 16'h0000);
        vec(I_X,  0, 0, A_RI);
        vec(I_X,  0, 0, B_REQ | B_ESC | B_END | A_RI);
        vec(I_X,  1, 0, B_REQ | B_ESC | B_END | A_RI | B_PC | B_CONC);
        vec(I_X,  0, 0, B_REQ);

        @(negedge clk);
        confere("reset_saidas", 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tabela.size(); i++)
            aplica($sformatf("vetor_%0d", i), tabela[i].instr, tabela[i].pronta,
                   tabela[i].z, tabela[i].esperado);

        // Back in BUSCA after the table; illegal encodings each end with a reset.
        testa_ilegal("ilegal_ff", I_X, 20);
        testa_ilegal("ilegal_f7", 32'h022081B3, 3);
        testa_ilegal("ilegal_lw", 32'h0000A183, 3);

        // Reset in the middle of an sd memory wait: request drops at once, no strobes.
        aplica("sdr_busca", I_SD, 1'b1, 1'b0, B_REQ | B_IR);
        aplica("sdr_decod", I_X, 1'b0, 1'b0, 16'h0000);
        aplica("sdr_exec",  I_X, 1'b0, 1'b0, A_RI);
        aplica("sdr_mem",   I_X, 1'b0, 1'b0, B_REQ | B_ESC | B_END | A_RI);
        mem_pronta = 1'b1;
        pulso_reset("sdr_reset");
        aplica("sdr_refetch", I_X, 1'b0, 1'b0, B_REQ);
        aplica("pos_add_busca", I_ADD, 1'b1, 1'b0, B_REQ | B_IR);
        aplica("pos_add_decod", I_X, 1'b0, 1'b0, 16'h0000);
        aplica("pos_add_exec",  I_X, 1'b0, 1'b0, A_RR);
        aplica("pos_add_escr",  I_X, 1'b0, 1'b0, B_REG | B_PC | B_CONC | A_RR);
        aplica("pos_add_idle",  I_X, 1'b0, 1'b0, B_REQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_falhas);
        $finish;
    end

endmodule

// File: doc/unidade_controle_ula.md
# unidade_controle_ula

Multicycle control unit for the RV64 datapath. It fetches each instruction over a req/ready memory handshake, decodes a base integer subset, and sequences the ALU operand selects, the add/subtract control and the output enable. It also drives register-file, PC and memory strobes. It sits between instruction memory / data memory and the datapath that holds the ALU, register file and PC.

## Interface
- BITS, 64, datapath width; only affects the `instrucao` latch width check (instructions are 32 bits, BITS ≥ 32)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- instrucao  in  32  memory read data, valid when mem_pronta=1 during BUSCA
- zero  in  1  datapath flag, ALU dout == 0
- mem_pronta  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_pronta
- mem_escreve  out  1  request is a write (sd)
- endereco_ula  out  1  0 = address from PC, 1 = from ALU result register
- carrega_ir  out  1  latch instruction register (pulse)
- carrega_pc  out  1  update PC (pulse)
- pc_fonte  out  1  0 = PC+4, 1 = branch target
- escreve_reg  out  1  register-file write enable (pulse)
- fonte_escrita  out  1  0 = ALU result, 1 = memory data
- escolhe_entrada1, escolhe_entrada2  out  2 each  ALU operand selects: 00 = rs1, 01 = rs2, 10 = immediate; 11 never driven
- subtraindo  out  1  ALU subtract
- soma_ou_subtrai  out  1  ALU output enable
- instrucao_concluida  out  1  one-cycle pulse when an instruction retires
- ilegal  out  1  sticky illegal-instruction flag

## Operation
- States: BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, ILEGAL.
- BUSCA:
  - Drives mem_req=1, mem_escreve=0, endereco_ula=0.
  - On mem_pronta=1: carrega_ir=1 (Mealy, same cycle), opcode/funct3/funct7 captured internally, next state DECODIFICA.
  - Otherwise stays in BUSCA.
- DECODIFICA:
  - Classifies the instruction:
    - add: opcode 0110011, f3 000, f7 0000000
    - sub: opcode 0110011, f3 000, f7 0100000
    - addi: opcode 0010011, f3 000
    - ld: opcode 0000011, f3 011
    - sd: opcode 0100011, f3 011
    - beq: opcode 1100011, f3 000
  - Any other encoding goes to ILEGAL. Supported encodings go to EXECUTA.
- EXECUTA:
  - Drives soma_ou_subtrai=1 with the operation's selects:
    - add: 00/01, subtraindo=0
    - sub: 00/01, subtraindo=1
    - addi, ld, sd: 00/10, subtraindo=0
    - beq: 00/01, subtraindo=1
  - Next state: add/sub/addi → ESCRITA; ld/sd → MEMORIA.
  - beq retires here: carrega_pc=1, pc_fonte=zero, instrucao_concluida=1, next state BUSCA.
- MEMORIA:
  - ALU controls are held as in EXECUTA.
  - Drives mem_req=1, endereco_ula=1, mem_escreve=(sd).
  - On mem_pronta: ld → ESCRITA; sd retires (carrega_pc=1, pc_fonte=0, instrucao_concluida=1) → BUSCA.
- ESCRITA:
  - ALU controls are held.
  - Drives escreve_reg=1, fonte_escrita=(ld), carrega_pc=1, pc_fonte=0, instrucao_concluida=1.
  - Next state BUSCA.
- ILEGAL: ilegal=1, all strobes 0, stays in ILEGAL until reset.
- Idle outputs: in any state not listed above, ALU selects=00, subtraindo=0, soma_ou_subtrai=0, and every strobe is 0.

## Timing
- Reset:
  - Asynchronous entry to BUSCA.
  - While reset=1 every output is 0, including mem_req and ilegal.
  - The first mem_req=1 appears on the first cycle after reset deasserts.
- Reset during MEMORIA or BUSCA drops mem_req combinationally. The transaction is abandoned and no strobe fires.
- Minimum latency with mem_pronta=1 on first request:
  - beq: 3 cycles
  - add/sub/addi/sd: 4 cycles
  - ld: 5 cycles
- Each memory wait cycle adds one cycle.
- mem_req and its address/write select stay stable until the cycle in which mem_pronta=1. mem_pronta outside BUSCA/MEMORIA is ignored.
- Exactly one carrega_pc and one instrucao_concluida per retired instruction. An illegal instruction produces neither.

## Structure
- Package `pkg_controle` holds:
  - state enum
  - opcode/funct constants
  - operand-select constants: SEL_RS1=00, SEL_RS2=01, SEL_IMM=10
  - operation enum: ADD, SUB, ADDI, LD, SD, BEQ, INV
- Sub-module `decodificador_instrucao`: combinational opcode/funct3/funct7 → operation enum. The FSM registers its output in DECODIFICA.

## Test plan
- add (0x002081B3), mem_pronta=1 immediately:
  - carrega_ir in cycle 1
  - EXECUTA selects 00/01, subtraindo=0, soma_ou_subtrai=1
  - escreve_reg, fonte_escrita=0 and carrega_pc in cycle 4; no further strobes
- ld (0x0000B183) with mem_pronta delayed 3 cycles in MEMORIA:
  - mem_req/endereco_ula=1 held 4 cycles
  - selects 00/10
  - escreve_reg with fonte_escrita=1 in cycle 8
- beq (0x00208463):
  - zero=1 → carrega_pc with pc_fonte=1 in cycle 3
  - zero=0 → pc_fonte=0
  - no escreve_reg in either case
- sd (0x0020B023): mem_escreve=1 only in MEMORIA; retires without escreve_reg.
- Illegal encoding 0xFFFFFFFF:
  - ilegal=1 from cycle 3, sticky for 20 cycles, all strobes 0
  - reset clears ilegal and fetch restarts
- Reset asserted mid-MEMORIA of a sd:
  - mem_req falls in the same cycle, no write strobe or retire
  - after release, BUSCA mem_req=1 with endereco_ula=0
